// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Grants one byte, strobes it out, then tracks tbr low-then-high before regranting.
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_write_en,
  output logic [7:0]           tx_write_line,
  input  logic                 tx_tbr,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] gid_q;
  logic [7:0]     data_q;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_nxt;
  logic           any;
  logic           grant;

  // first valid index at or above ptr, wrapping
  always_comb begin
    logic [IDW:0] sum;
    sum = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      if (!any && req_valid[sum[IDW-1:0]]) begin
        any = 1'b1;
        win = sum[IDW-1:0];
      end
    end
  end

  // rst_n gates the accept so outputs read idle while reset is held
  assign grant = rst_n && (state_q == IDLE)
              && en && tx_tbr && any;

  assign ptr_nxt = (win == IDW'(NUM_REQ-1))
                 ? '0 : win + IDW'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (grant) state_d = LAUNCH;
      LAUNCH:     state_d = WAIT_START;
      WAIT_START: if (!tx_tbr) state_d = WAIT_END;
      WAIT_END:   if (tx_tbr) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q  <= ptr_nxt;
        gid_q  <= win;
        data_q <= req_data[{win, 3'b000} +: 8];
      end
    end
  end

  assign req_ready     = grant ? (NUM_REQ'(1) << win) : '0;
  assign tx_write_en   = (state_q == LAUNCH);
  assign tx_write_line = data_q;
  assign grant_id      = gid_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == WAIT_END) && tx_tbr;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table plus corner-case sequences,
// with grant/byte scoreboard queues and a simple transmitter model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_write_en;
  logic [7:0]  tx_write_line;
  logic        tx_tbr;
  logic [1:0]  grant_id;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_write_en  (tx_write_en),
    .tx_write_line(tx_write_line),
    .tx_tbr       (tx_tbr),
    .grant_id     (grant_id),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         exp_gnt[$];
  int         exp_id[$];
  logic [7:0] exp_b[$];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(int id, logic [7:0] b);
    exp_gnt.push_back(id);
    exp_id.push_back(id);
    exp_b.push_back(b);
  endfunction

  // scoreboard monitor
  logic prev_we;
  int   mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (req_ready != 4'b0000) begin
        if (exp_gnt.size() == 0)
          chk("unexpected_ready", 32'(req_ready), 0);
        else begin
          mon_e = exp_gnt.pop_front();
          chk("req_ready", 32'(req_ready), 32'(4'b0001 << mon_e));
        end
      end
      if (tx_write_en) begin
        chk("we_single", 32'(prev_we), 0);
        if (exp_id.size() == 0)
          chk("unexpected_we", 32'(tx_write_en), 0);
        else begin
          chk("tx_grant_id", 32'(grant_id), exp_id.pop_front());
          chk("tx_line", 32'(tx_write_line), 32'(exp_b.pop_front()));
        end
      end
      prev_we = tx_write_en;
    end
  end

  // requester / transmitter model state
  int         cyc = 0;
  int         t_rr = 0;
  int         t_we = 0;
  int         t_fd = 0;
  int         fd_cnt = 0;
  logic       last_fd, last_we, last_tbr;
  logic [3:0] last_rr;
  logic       drop_all;
  logic [3:0] reload;
  int         hold, frame_len, wcnt, cnt;
  logic       pending;

  task automatic tick();
    logic [3:0] rr;
    logic       we;
    @(negedge clk);
    cyc++;
    rr       = req_ready;
    we       = tx_write_en;
    last_rr  = rr;
    last_we  = we;
    last_fd  = frame_done;
    last_tbr = tx_tbr;
    if (rr != 4'b0000) t_rr = cyc;
    if (we) t_we = cyc;
    if (frame_done) begin
      t_fd = cyc;
      fd_cnt++;
    end
    @(posedge clk);
    #1;
    if (rr != 4'b0000)
      req_valid = drop_all ? 4'b0000
                           : (req_valid & ~(rr & ~reload));
    if (!rst_n) begin
      tx_tbr  = 1'b1;
      pending = 1'b0;
      wcnt    = 0;
      cnt     = 0;
    end else if (we) begin
      if (hold == 0) begin
        tx_tbr = 1'b0;
        cnt    = frame_len;
      end else begin
        pending = 1'b1;
        wcnt    = hold;
      end
    end else if (pending) begin
      wcnt--;
      if (wcnt == 0) begin
        pending = 1'b0;
        tx_tbr  = 1'b0;
        cnt     = frame_len;
      end
    end else if (!tx_tbr) begin
      cnt--;
      if (cnt == 0) tx_tbr = 1'b1;
    end
  endtask

  task automatic wait_fd(int n);
    int target;
    target = fd_cnt + n;
    for (int i = 0; i < 60 * n && fd_cnt < target; i++)
      tick();
    chk("frame_done_wait", 32'(fd_cnt >= target), 1);
  endtask

  task automatic wait_we();
    last_we = 1'b0;
    for (int i = 0; i < 60 && !last_we; i++)
      tick();
    chk("we_wait", 32'(last_we), 1);
  endtask

  task automatic check_idle_off(string tag);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_ready"}, 32'(last_rr), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_we"}, 32'(tx_write_en), 0);
    chk({tag, "_line"}, 32'(tx_write_line), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          id;
    logic [7:0]  b;
  } vec_t;

  vec_t tbl[8];
  logic saw_low;

  initial begin
    tbl[0] = '{4'b0100, 32'h00A50000, 2, 8'hA5};
    tbl[1] = '{4'b1010, 32'h44332211, 3, 8'h44};
    tbl[2] = '{4'b1010, 32'h44332211, 1, 8'h22};
    tbl[3] = '{4'b0001, 32'h000000C3, 0, 8'hC3};
    tbl[4] = '{4'b1001, 32'h5A0000E1, 3, 8'h5A};
    tbl[5] = '{4'b1111, 32'h78563412, 0, 8'h12};
    tbl[6] = '{4'b0110, 32'h00BBAA00, 1, 8'hAA};
    tbl[7] = '{4'b0011, 32'h0000F00D, 0, 8'h0D};

    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_tbr    = 1'b1;
    drop_all  = 1'b1;
    reload    = 4'b0000;
    hold      = 0;
    frame_len = 3;
    pending   = 1'b0;
    wcnt      = 0;
    cnt       = 0;
    #3;
    check_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single-grant vectors
    foreach (tbl[i]) begin
      req_data = tbl[i].data;
      push_exp(tbl[i].id, tbl[i].b);
      en        = 1'b1;
      req_valid = tbl[i].valid;
      wait_fd(1);
      chk("vec_grant_id", 32'(grant_id), tbl[i].id);
      chk("vec_ready_to_we", t_we - t_rr, 1);
      chk("vec_we_to_fd", t_fd - t_we, 4);
      chk("vec_busy_after", 32'(busy), 0);
    end

    // round robin with re-asserting requesters
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    drop_all = 1'b0;
    reload   = 4'b1111;
    req_data = 32'h13121110;
    push_exp(0, 8'h10);
    push_exp(1, 8'h11);
    push_exp(2, 8'h12);
    push_exp(3, 8'h13);
    push_exp(0, 8'h10);
    req_valid = 4'b1111;
    wait_fd(5);
    req_valid = 4'b0000;
    reload    = 4'b0000;
    chk("rr_last_id", 32'(grant_id), 0);

    // ptr=2 with requesters 1 and 3
    drop_all = 1'b1;
    push_exp(1, 8'h11);
    req_valid = 4'b0010;
    wait_fd(1);
    drop_all = 1'b0;
    push_exp(3, 8'h13);
    push_exp(1, 8'h11);
    req_valid = 4'b1010;
    wait_fd(2);
    chk("skip_last_id", 32'(grant_id), 1);

    // enable gating and mid-frame disable
    drop_all  = 1'b1;
    en        = 1'b0;
    req_valid = 4'b1111;
    check_idle_off("en_off");
    push_exp(2, 8'h12);
    en = 1'b1;
    wait_we();
    tick();
    chk("en_wait_end_busy", 32'(busy), 1);
    en        = 1'b0;
    req_valid = 4'b1111;
    wait_fd(1);
    check_idle_off("en_off2");
    push_exp(3, 8'h13);
    en = 1'b1;
    wait_fd(1);
    chk("en_on_id", 32'(grant_id), 3);

    // transmitter slow to drop tbr
    hold      = 3;
    req_data  = 32'h000000C7;
    push_exp(0, 8'hC7);
    req_valid = 4'b0001;
    saw_low   = 1'b0;
    last_fd   = 1'b0;
    for (int i = 0; i < 60 && !last_fd; i++) begin
      tick();
      if (!last_fd && !last_tbr) saw_low = 1'b1;
    end
    chk("slow_fd_seen", 32'(last_fd), 1);
    chk("slow_fd_after_low", 32'(saw_low), 1);
    chk("slow_we_to_fd", t_fd - t_we, 7);
    hold = 0;

    // reset during WAIT_END
    req_data = 32'h44332211;
    push_exp(2, 8'h33);
    req_valid = 4'b0100;
    wait_we();
    tick();
    chk("mid_busy", 32'(busy), 1);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_reset_vals("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    push_exp(0, 8'h11);
    wait_fd(1);
    chk("post_rst_id", 32'(grant_id), 0);

    tick();
    chk("sb_gnt_empty", exp_gnt.size(), 0);
    chk("sb_tx_empty", exp_id.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d",
             n_err);
    $fatal(1, "watchdog");
  end

endmodule
